ex_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage. Consumes decode-to-execute

---
 rtl/ex_muldiv.sv | 143 ++++++++++++++
 tb/tb_ex_muldiv.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage.
// Holds the pipeline via stall_o until the result is presented with a one-cycle done_o pulse.
module ex_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  stall_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_t         state_q, state_d;
  op_e            op_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic           neg_res_q, neg_rem_q;
  logic [W-1:0]   opnd_q;
  logic [2*W-1:0] acc_q, acc_d;

  logic           signed_a, signed_b, sa, sb;
  logic [W-1:0]   a_mag, b_mag;
  logic           div_zero, div_ovf, fast, accept, last;
  logic [W-1:0]   fast_res, final_res;
  logic [W-1:0]   addend;
  logic [W:0]     mul_sum, shifted, diff;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (op_e'(op_i))
      OP_MULH, OP_DIV, OP_REM: begin signed_a = 1'b1; signed_b = 1'b1; end
      OP_MULHSU:               signed_a = 1'b1;
      default: ;
    endcase
  end

  assign sa    = signed_a & a_i[W-1];
  assign sb    = signed_b & b_i[W-1];
  assign a_mag = sa ? -a_i : a_i;
  assign b_mag = sb ? -b_i : b_i;

  assign div_zero = op_i[2] & (b_i == '0);
  assign div_ovf  = ((op_e'(op_i) == OP_DIV) || (op_e'(op_i) == OP_REM)) &&
                    (a_i == MIN_NEG) && (b_i == '1);
  assign fast     = div_zero | div_ovf;
  // op_i[1] separates REM/REMU from DIV/DIVU among the divide ops.
  assign fast_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : MIN_NEG);

  assign accept = (state_q == IDLE) & valid_i & ~flush_i;
  assign last   = (state_q == CALC) && (cnt_q == CNT_WIDTH'(W - 1));

  // Multiply keeps {product_hi, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    addend  = acc_q[0] ? opnd_q : '0;
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};
    shifted = acc_q[2*W-1:W-1];
    diff    = shifted - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!diff[W]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
      else          acc_d = {shifted[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[W-1:1]};
    end
  end

  always_comb begin
    prod = neg_res_q ? -acc_d : acc_d;
    quo  = neg_res_q ? -(acc_d[W-1:0]) : acc_d[W-1:0];
    rem  = neg_rem_q ? -(acc_d[2*W-1:W]) : acc_d[2*W-1:W];
    case (op_q)
      OP_MUL:                        final_res = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[2*W-1:W];
      OP_DIV, OP_DIVU:               final_res = quo;
      default:                       final_res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (valid_i) state_d = fast ? DONE : CALC;
        CALC:    if (last) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the accumulators are cleared on reset too, so a reset mid-operation leaves no stale datapath state.
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_o  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_e'(op_i);
        neg_res_q <= sa ^ sb;
        neg_rem_q <= sa;
        cnt_q     <= '0;
        opnd_q    <= op_i[2] ? b_mag : a_mag;
        acc_q     <= {{W{1'b0}}, (op_i[2] ? a_mag : b_mag)};
        if (fast) result_o <= fast_res;
      end else if ((state_q == CALC) && !flush_i) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CNT_WIDTH'(1);
        if (last) result_o <= final_res;
      end
    end
  end

  assign done_o  = (state_q == DONE) & ~flush_i;
  assign busy_o  = (state_q == CALC);
  assign stall_o = valid_i & ~done_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected results, a monitor pops them on done_o.
module tb_ex_muldiv;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_n_i, valid_i, flush_i;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i, result_o;
  logic         done_o, busy_o, stall_o;

  typedef struct {
    string        name;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_muldiv #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .flush_i(flush_i),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .result_o(result_o),
    .done_o(done_o), .busy_o(busy_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i === 1'b1 && done_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done_o), '0);
        end else begin
          e = sb.pop_front();
          check(e.name, result_o, e.val);
        end
      end
    end
  end

  // Counts edges after the accept edge until done_o is seen (bounded).
  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    while (done_o !== 1'b1 && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check({name, "_done"}, 32'(done_o), 32'd1);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_stall"}, 32'(stall_o), 32'd0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string name, input int lat);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    sb.push_back('{name, exp});
    @(posedge clk_i); #1;
    a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D;
    if (lat == 0) check({name, "_busy"}, 32'(busy_o), 32'd0);
    else          check({name, "_busy"}, 32'(busy_o & stall_o), 32'd1);
    wait_done(name, lat);
    valid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_result", result_o, '0);
    check("rst_done", 32'(done_o), '0);
    check("rst_busy", 32'(busy_o), '0);
    check("rst_stall", 32'(stall_o), '0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Multiplies: 7 * -3, and the high-half variants.
    do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_neg",  32);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min", 32);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max", 32);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu",   32);
    do_op(3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_lo",   32);

    // Divides: unsigned and signed, both operand sign combinations.
    do_op(3'd5, 32'd100,       32'd7,         32'd14,        "divu",     32);
    do_op(3'd7, 32'd100,       32'd7,         32'd2,         "remu",     32);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg",  32);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg",  32);
    do_op(3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, "div_negb", 32);
    do_op(3'd6, 32'd100,       32'hFFFF_FFF9, 32'd2,         "rem_negb", 32);

    // Fast path: divide by zero and signed overflow.
    do_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_zero",  0);
    do_op(3'd7, 32'd5,         32'd0,         32'd5,         "remu_zero", 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",   0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf",   0);

    // Back-to-back: valid_i held through DONE; next op accepted only in the following IDLE cycle.
    op_i = 3'd5; a_i = 32'd100; b_i = 32'd7; valid_i = 1'b1;
    sb.push_back('{"b2b_first", 32'd14});
    @(posedge clk_i); #1;
    wait_done("b2b_first", 32);
    op_i = 3'd7; a_i = 32'd100; b_i = 32'd7;
    sb.push_back('{"b2b_second", 32'd2});
    @(posedge clk_i); #1;
    check("b2b_idle_busy", 32'(busy_o), '0);
    check("b2b_idle_stall", 32'(stall_o), 32'd1);
    @(posedge clk_i); #1;
    check("b2b_accept_busy", 32'(busy_o), 32'd1);
    a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D;
    wait_done("b2b_second", 32);
    valid_i = 1'b0;
    @(posedge clk_i); #1;

    // Flush at iteration 10: no done, back to idle, result_o keeps the previous value.
    op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; valid_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (10) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    check("flush_done", 32'(done_o), '0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush_busy", 32'(busy_o), '0);
    check("flush_hold", result_o, 32'd2);
    do_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, "after_flush", 32);

    // Reset pulsed mid-CALC: outputs clear at once and no done pulse follows.
    op_i = 3'd3; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; valid_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (5) @(posedge clk_i);
    #3;
    rst_n_i = 1'b0; valid_i = 1'b0;
    #1;
    check("midrst_result", result_o, '0);
    check("midrst_busy", 32'(busy_o), '0);
    check("midrst_done", 32'(done_o), '0);
    #10;
    rst_n_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    check("midrst_result_after", result_o, '0);

    check("sb_drain", 32'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
